// File: rtl/nand_gate_arbiter.sv
// Round-robin arbiter that shares one registered NAND evaluation unit between N_REQ requesters.
// Optional truth-table sweep mode is compiled in with `define GATE_ARB_SWEEP_EN.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | waiting; picks the next requester round-robin from r_ptr
// S_EVAL  | latched operands go through the NAND into r_result
// S_RESP  | done pulse for the granted requester, count and pointer update
// S_SWEEP | (sweep build only) evaluates rows 00..11 into sweep_table
module nand_gate_arbiter #(
    parameter int N_REQ = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_REQ-1:0] req,
    input  logic [N_REQ-1:0] a_in,
    input  logic [N_REQ-1:0] b_in,
    output logic [N_REQ-1:0] grant,
    output logic [N_REQ-1:0] done,
    output logic             result,
    output logic             busy,
    output logic [CNT_W-1:0] op_count
`ifdef GATE_ARB_SWEEP_EN
    ,
    input  logic             sweep_start,
    output logic [3:0]       sweep_table,
    output logic             sweep_done
`endif
);

    localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam logic [N_REQ-1:0] ONE_HOT0 = {{(N_REQ-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_EVAL  = 2'd1,
        S_RESP  = 2'd2
`ifdef GATE_ARB_SWEEP_EN
        ,
        S_SWEEP = 2'd3
`endif
    } state_t;

    state_t             r_state;
    logic [PTR_W-1:0]   r_ptr;
    logic [PTR_W-1:0]   r_gid;
    logic               r_op_a;
    logic               r_op_b;
    logic [N_REQ-1:0]   r_grant;
    logic [N_REQ-1:0]   r_done;
    logic               r_result;
    logic               r_busy;
    logic [CNT_W-1:0]   r_op_count;

    logic [PTR_W-1:0]   w_sel;
    logic               w_any;
    logic               w_sweep_go;

`ifdef GATE_ARB_SWEEP_EN
    logic [1:0]         r_row;
    logic [3:0]         r_sweep_table;
    logic               r_sweep_done;

    assign w_sweep_go  = sweep_start;
    assign sweep_table = r_sweep_table;
    assign sweep_done  = r_sweep_done;
`else
    assign w_sweep_go  = 1'b0;
`endif

    // Walk the offsets from the highest down so the closest request to r_ptr wins last.
    always_comb begin
        logic [PTR_W:0] w_idx;
        w_idx = '0;
        w_sel = '0;
        w_any = 1'b0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            w_idx = {1'b0, r_ptr} + (PTR_W+1)'(i);
            if (w_idx >= (PTR_W+1)'(N_REQ))
                w_idx = w_idx - (PTR_W+1)'(N_REQ);
            if (req[w_idx[PTR_W-1:0]]) begin
                w_sel = w_idx[PTR_W-1:0];
                w_any = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_ptr      <= '0;
            r_gid      <= '0;
            r_op_a     <= 1'b0;
            r_op_b     <= 1'b0;
            r_grant    <= '0;
            r_done     <= '0;
            r_result   <= 1'b0;
            r_busy     <= 1'b0;
            r_op_count <= '0;
`ifdef GATE_ARB_SWEEP_EN
            r_row         <= 2'd0;
            r_sweep_table <= 4'd0;
            r_sweep_done  <= 1'b0;
`endif
        end else begin
            r_done <= '0;
`ifdef GATE_ARB_SWEEP_EN
            r_sweep_done <= 1'b0;
`endif
            case (r_state)
                S_IDLE: begin
                    if (w_sweep_go) begin
`ifdef GATE_ARB_SWEEP_EN
                        r_state <= S_SWEEP;
                        r_row   <= 2'd0;
                        r_busy  <= 1'b1;
`endif
                    end else if (w_any) begin
                        r_op_a  <= a_in[w_sel];
                        r_op_b  <= b_in[w_sel];
                        r_gid   <= w_sel;
                        r_grant <= ONE_HOT0 << w_sel;
                        r_busy  <= 1'b1;
                        r_state <= S_EVAL;
                    end
                end
                S_EVAL: begin
                    r_result <= ~(r_op_a & r_op_b);
                    r_done   <= ONE_HOT0 << r_gid;
                    r_state  <= S_RESP;
                end
                S_RESP: begin
                    r_grant    <= '0;
                    r_busy     <= 1'b0;
                    r_op_count <= r_op_count + CNT_W'(1);
                    if (r_gid == PTR_W'(N_REQ - 1))
                        r_ptr <= '0;
                    else
                        r_ptr <= r_gid + PTR_W'(1);
                    r_state <= S_IDLE;
                end
`ifdef GATE_ARB_SWEEP_EN
                S_SWEEP: begin
                    r_sweep_table[r_row] <= ~(r_row[1] & r_row[0]);
                    if (r_row == 2'd3) begin
                        r_sweep_done <= 1'b1;
                        r_busy       <= 1'b0;
                        r_state      <= S_IDLE;
                    end else begin
                        r_row <= r_row + 2'd1;
                    end
                end
`endif
                default: begin
                    r_state <= S_IDLE;
                    r_grant <= '0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign grant    = r_grant;
    assign done     = r_done;
    assign result   = r_result;
    assign busy     = r_busy;
    assign op_count = r_op_count;

endmodule
